// File: rtl/coin_change_dispenser.sv
// Change payout engine: greedy quarter/dime/nickel selection against live
// inventory, driving one timed eject pulse at a time into the coin hopper.
module coin_change_dispenser #(
  parameter int AMT_W        = 6,
  parameter int INV_W        = 8,
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 1,
  parameter int N_INIT       = 20,
  parameter int D_INIT       = 20,
  parameter int Q_INIT       = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             change_req,
  input  logic [AMT_W-1:0] change_amt,
  input  logic             hopper_rdy,
  input  logic             inv_load,
  input  logic [INV_W-1:0] n_load,
  input  logic [INV_W-1:0] d_load,
  input  logic [INV_W-1:0] q_load,
  output logic             N_out,
  output logic             D_out,
  output logic             Q_out,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic [INV_W-1:0] n_cnt,
  output logic [INV_W-1:0] d_cnt,
  output logic [INV_W-1:0] q_cnt
);

  typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;
  typedef enum logic [1:0] {COIN_NONE, COIN_N, COIN_D, COIN_Q} coin_t;

  // One shared timer covers both the pulse-high and gap-low phases.
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  state_t          state, state_nxt;
  coin_t           cand;
  logic [TW-1:0]   timer;
  logic            pulse_end, gap_end;

  assign pulse_end = (timer == TW'(PULSE_CYCLES - 1));
  assign gap_end   = (timer == TW'(GAP_CYCLES - 1));

  // Greedy pick; a denomination with an empty counter is never chosen.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    cand = COIN_NONE;
    if (remaining >= AMT_W'(5) && q_cnt != '0)      cand = COIN_Q;
    else if (remaining >= AMT_W'(2) && d_cnt != '0) cand = COIN_D;
    else if (remaining >= AMT_W'(1) && n_cnt != '0) cand = COIN_N;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (change_req) state_nxt = SELECT;
      SELECT:  if (cand == COIN_NONE) state_nxt = DONE;
               else if (hopper_rdy)   state_nxt = PULSE;
      PULSE:   if (pulse_end) state_nxt = GAP;
      GAP:     if (gap_end)   state_nxt = SELECT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Registered outputs and datapath; counters reset to their stocked levels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      N_out     <= 1'b0;
      D_out     <= 1'b0;
      Q_out     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      remaining <= '0;
      timer     <= '0;
      n_cnt     <= INV_W'(N_INIT);
      d_cnt     <= INV_W'(D_INIT);
      q_cnt     <= INV_W'(Q_INIT);
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (change_req) begin
            remaining <= change_amt;
            short     <= 1'b0;
            busy      <= 1'b1;
          end else if (inv_load) begin
            n_cnt <= n_load;
            d_cnt <= d_load;
            q_cnt <= q_load;
          end
        end
        SELECT: begin
          if (cand == COIN_NONE) begin
            short <= (remaining != '0);
          end else if (hopper_rdy) begin
            timer <= '0;
            unique case (cand)
              COIN_Q: begin
                Q_out     <= 1'b1;
                remaining <= remaining - AMT_W'(5);
                q_cnt     <= q_cnt - INV_W'(1);
              end
              COIN_D: begin
                D_out     <= 1'b1;
                remaining <= remaining - AMT_W'(2);
                d_cnt     <= d_cnt - INV_W'(1);
              end
              default: begin
                N_out     <= 1'b1;
                remaining <= remaining - AMT_W'(1);
                n_cnt     <= n_cnt - INV_W'(1);
              end
            endcase
          end
        end
        PULSE: begin
          if (pulse_end) begin
            N_out <= 1'b0;
            D_out <= 1'b0;
            Q_out <= 1'b0;
            timer <= '0;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        GAP: begin
          if (!gap_end) timer <= timer + TW'(1);
        end
        DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_coin_change_dispenser.sv
// Directed self-checking bench for coin_change_dispenser using the default
// parameters (2-cycle pulses, 1-cycle gap, 20 of each coin after reset).
module tb_coin_change_dispenser;

  logic       clk = 1'b0;
  logic       reset, change_req, hopper_rdy, inv_load;
  logic [5:0] change_amt;
  logic [7:0] n_load, d_load, q_load;
  logic       N_out, D_out, Q_out, busy, done, short;
  logic [5:0] remaining;
  logic [7:0] n_cnt, d_cnt, q_cnt;

  int compared   = 0;
  int mismatched = 0;

  coin_change_dispenser dut (
    .clk(clk), .reset(reset), .change_req(change_req), .change_amt(change_amt),
    .hopper_rdy(hopper_rdy), .inv_load(inv_load),
    .n_load(n_load), .d_load(d_load), .q_load(q_load),
    .N_out(N_out), .D_out(D_out), .Q_out(Q_out),
    .busy(busy), .done(done), .short(short), .remaining(remaining),
    .n_cnt(n_cnt), .d_cnt(d_cnt), .q_cnt(q_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [5:0] amt);
    change_amt = amt;
    change_req = 1'b1;
    step();
    change_req = 1'b0;
  endtask

  // Observes eject lines until done: records the coin order, flags bad pulse
  // widths or overlapping lines, and optionally injects ignored requests.
  task automatic wait_done(input int budget, input int inject,
                           output int cycles, output string seq, output int bad);
    logic [2:0] outs, prev;
    int width;
    cycles = -1; seq = ""; bad = 0; prev = 3'b000; width = 0;
    for (int k = 1; k <= budget; k++) begin
      step();
      if (k == inject) begin
        change_amt = 6'd10; change_req = 1'b1; inv_load = 1'b1;
        n_load = 8'd1; d_load = 8'd1; q_load = 8'd1;
      end else if (k == inject + 1) begin
        change_req = 1'b0; inv_load = 1'b0;
      end
      outs = {Q_out, D_out, N_out};
      if ($countones(outs) > 1) bad++;
      if (outs != 3'b000) begin
        if (prev == 3'b000) begin
          width = 1;
          seq = {seq, outs[2] ? "Q" : outs[1] ? "D" : "N"};
        end else if (outs == prev) width++;
        else bad++;
      end else if (prev != 3'b000 && width != 2) bad++;
      prev = outs;
      if (done === 1'b1) begin
        cycles = k;
        if (outs != 3'b000) bad++;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; change_req = 1'b0; hopper_rdy = 1'b1; inv_load = 1'b0;
    change_amt = '0; n_load = '0; d_load = '0; q_load = '0;
    step(); step();
    reset = 1'b1;
    step();
    compared++; if ({N_out, D_out, Q_out, busy, done, short} !== 6'b0) begin
      mismatched++; $display("FAIL reset_flags got %b want 000000", {N_out, D_out, Q_out, busy, done, short}); end
    compared++; if (remaining !== 6'd0) begin
      mismatched++; $display("FAIL reset_remaining got %0d want 0", remaining); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd20, 8'd20, 8'd20}) begin
      mismatched++; $display("FAIL reset_counts got %0d/%0d/%0d want 20/20/20", n_cnt, d_cnt, q_cnt); end
  endtask

  task automatic test_greedy();
    int cyc, bad; string seq;
    hopper_rdy = 1'b1;
    start(6'd8);
    compared++; if (busy !== 1'b1) begin
      mismatched++; $display("FAIL greedy_busy got %b want 1", busy); end
    wait_done(40, -1, cyc, seq, bad);
    compared++; if (seq != "QDN") begin
      mismatched++; $display("FAIL greedy_seq got '%s' want 'QDN'", seq); end
    compared++; if (bad !== 0) begin
      mismatched++; $display("FAIL greedy_pulse_shape got %0d errors want 0", bad); end
    compared++; if (cyc !== 14) begin
      mismatched++; $display("FAIL greedy_done_latency got %0d want 14", cyc); end
    compared++; if (remaining !== 6'd0 || short !== 1'b0 || busy !== 1'b0) begin
      mismatched++; $display("FAIL greedy_end got rem=%0d short=%b busy=%b want 0/0/0", remaining, short, busy); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd19, 8'd19, 8'd19}) begin
      mismatched++; $display("FAIL greedy_counts got %0d/%0d/%0d want 19/19/19", n_cnt, d_cnt, q_cnt); end
    step();
    compared++; if (done !== 1'b0) begin
      mismatched++; $display("FAIL greedy_done_width got %b want 0", done); end
  endtask

  task automatic test_short();
    int cyc, bad; string seq;
    inv_load = 1'b1; n_load = 8'd1; d_load = 8'd1; q_load = 8'd0;
    step();
    inv_load = 1'b0;
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd1, 8'd1, 8'd0}) begin
      mismatched++; $display("FAIL load_counts got %0d/%0d/%0d want 1/1/0", n_cnt, d_cnt, q_cnt); end
    start(6'd5);
    wait_done(40, -1, cyc, seq, bad);
    compared++; if (seq != "DN" || bad !== 0) begin
      mismatched++; $display("FAIL short_seq got '%s' bad=%0d want 'DN' bad=0", seq, bad); end
    compared++; if (cyc !== 10) begin
      mismatched++; $display("FAIL short_done_latency got %0d want 10", cyc); end
    compared++; if (remaining !== 6'd2 || short !== 1'b1) begin
      mismatched++; $display("FAIL short_flag got rem=%0d short=%b want 2/1", remaining, short); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== 24'd0) begin
      mismatched++; $display("FAIL short_counts got %0d/%0d/%0d want 0/0/0", n_cnt, d_cnt, q_cnt); end
  endtask

  task automatic test_hopper_stall();
    int cyc, bad, stall_err; string seq;
    inv_load = 1'b1; n_load = 8'd5; d_load = 8'd5; q_load = 8'd5;
    step();
    inv_load = 1'b0;
    hopper_rdy = 1'b0;
    start(6'd3);
    stall_err = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if ({N_out, D_out, Q_out} != 3'b000 || busy !== 1'b1 || remaining !== 6'd3) stall_err++;
    end
    compared++; if (stall_err !== 0) begin
      mismatched++; $display("FAIL stall_hold got %0d bad cycles want 0", stall_err); end
    hopper_rdy = 1'b1;
    wait_done(40, -1, cyc, seq, bad);
    compared++; if (seq != "DN" || bad !== 0) begin
      mismatched++; $display("FAIL stall_seq got '%s' bad=%0d want 'DN' bad=0", seq, bad); end
    compared++; if (cyc !== 10) begin
      mismatched++; $display("FAIL stall_done_latency got %0d want 10", cyc); end
    compared++; if (short !== 1'b0 || remaining !== 6'd0) begin
      mismatched++; $display("FAIL stall_end got short=%b rem=%0d want 0/0", short, remaining); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd4, 8'd4, 8'd5}) begin
      mismatched++; $display("FAIL stall_counts got %0d/%0d/%0d want 4/4/5", n_cnt, d_cnt, q_cnt); end
  endtask

  task automatic test_zero_amount();
    int cyc, bad; string seq;
    start(6'd0);
    wait_done(20, -1, cyc, seq, bad);
    compared++; if (seq != "" || cyc !== 2) begin
      mismatched++; $display("FAIL zero_amt got seq='%s' latency=%0d want ''/2", seq, cyc); end
    compared++; if (short !== 1'b0 || {n_cnt, d_cnt, q_cnt} !== {8'd4, 8'd4, 8'd5}) begin
      mismatched++; $display("FAIL zero_state got short=%b counts=%0d/%0d/%0d want 0 4/4/5", short, n_cnt, d_cnt, q_cnt); end
  endtask

  task automatic test_reset_mid_payout();
    int cyc, bad, stray; string seq;
    start(6'd5);
    step();
    compared++; if (Q_out !== 1'b1 || q_cnt !== 8'd4) begin
      mismatched++; $display("FAIL abort_pre got Q_out=%b q_cnt=%0d want 1/4", Q_out, q_cnt); end
    reset = 1'b0;
    step();
    reset = 1'b1;
    compared++; if ({Q_out, busy, done} !== 3'b000) begin
      mismatched++; $display("FAIL abort_outs got Q/busy/done=%b want 000", {Q_out, busy, done}); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd20, 8'd20, 8'd20}) begin
      mismatched++; $display("FAIL abort_counts got %0d/%0d/%0d want 20/20/20", n_cnt, d_cnt, q_cnt); end
    stray = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if ({N_out, D_out, Q_out, done} != 4'b0) stray++;
    end
    compared++; if (stray !== 0) begin
      mismatched++; $display("FAIL abort_quiet got %0d active cycles want 0", stray); end
    start(6'd1);
    wait_done(20, -1, cyc, seq, bad);
    compared++; if (seq != "N" || bad !== 0 || cyc !== 6) begin
      mismatched++; $display("FAIL abort_restart got seq='%s' bad=%0d latency=%0d want 'N'/0/6", seq, bad, cyc); end
  endtask

  task automatic test_ignore_while_busy();
    int cyc, bad; string seq;
    start(6'd7);
    wait_done(40, 3, cyc, seq, bad);
    compared++; if (seq != "QD" || bad !== 0 || cyc !== 10) begin
      mismatched++; $display("FAIL busy_ignore got seq='%s' bad=%0d latency=%0d want 'QD'/0/10", seq, bad, cyc); end
    compared++; if (remaining !== 6'd0 || short !== 1'b0) begin
      mismatched++; $display("FAIL busy_end got rem=%0d short=%b want 0/0", remaining, short); end
    compared++; if ({n_cnt, d_cnt, q_cnt} !== {8'd19, 8'd19, 8'd19}) begin
      mismatched++; $display("FAIL busy_counts got %0d/%0d/%0d want 19/19/19", n_cnt, d_cnt, q_cnt); end
    step(); step();
    compared++; if (busy !== 1'b0) begin
      mismatched++; $display("FAIL busy_no_queue got busy=%b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_greedy();
    test_short();
    test_hopper_stall();
    test_zero_amount();
    test_reset_mid_payout();
    test_ignore_while_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/coin_change_dispenser.md
Name: coin_change_dispenser

Overview:
- Pays out change owed by the vending controller.
- Accepts a change amount in nickel units and drives the coin-hopper eject lines `N_out`/`D_out`/`Q_out` with timed pulses. Uses greedy quarter/dime/nickel selection against per-denomination inventory counters.
- Sits downstream of the vending FSM, between it and the physical coin hopper. Reports completion and whether change was short-paid.

Parameters:
- AMT_W, 6, width of change amount in nickels (max 63 = $3.15)
- INV_W, 8, width of each coin inventory counter
- PULSE_CYCLES, 2, eject pulse width in clocks (>=1)
- GAP_CYCLES, 1, minimum low time between consecutive ejects (>=1)
- N_INIT, 20, nickel inventory after reset
- D_INIT, 20, dime inventory after reset
- Q_INIT, 20, quarter inventory after reset

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- change_req  in  1  start request, sampled only in IDLE
- change_amt  in  AMT_W  amount owed in nickels, latched with change_req
- hopper_rdy  in  1  hopper can accept an eject pulse
- inv_load  in  1  load inventory counters, honoured only in IDLE
- n_load, d_load, q_load  in  INV_W each  inventory values for inv_load
- N_out  out  1  nickel eject pulse
- D_out  out  1  dime eject pulse
- Q_out  out  1  quarter eject pulse
- busy  out  1  high from the cycle after request acceptance until return to IDLE
- done  out  1  one-cycle completion pulse
- short  out  1  last transaction could not pay full amount; held until next accepted request
- remaining  out  AMT_W  nickels still owed, live
- n_cnt, d_cnt, q_cnt  out  INV_W each  current inventory

Behaviour:
- All outputs registered.
- Reset (`reset`=0 at edge): state IDLE; `N_out`/`D_out`/`Q_out`/`busy`/`done`/`short` = 0; `remaining` = 0; counters = N_INIT/D_INIT/Q_INIT.
- Reset mid-payout aborts immediately: eject line drops on that edge. No done pulse.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - `change_req`=1 → `remaining`<=`change_amt`, `short`<=0, `busy`<=1, next SELECT.
  - Else if `inv_load`=1 → counters <= load values.
  - If both are high, the request wins and the load is dropped.
- SELECT (1 cycle minimum), priority order:
  - `remaining`==0 → DONE, `short`<=0.
  - `remaining`>=5 and `q_cnt`>0 → candidate Q.
  - Else `remaining`>=2 and `d_cnt`>0 → candidate D.
  - Else `remaining`>=1 and `n_cnt`>0 → candidate N.
  - Else no candidate → DONE, `short`<=1.
  - Candidate present and `hopper_rdy`=1 → PULSE. On this edge: assert that coin's out line; decrement `remaining` by 5/2/1; decrement the coin counter by 1.
  - Candidate present and `hopper_rdy`=0 → stay in SELECT. No outputs change; candidate is re-evaluated each cycle.
- PULSE: the selected out line is high for exactly PULSE_CYCLES cycles, then drops and the FSM enters GAP. Only one of `N_out`/`D_out`/`Q_out` is ever high.
- GAP: all out lines low for GAP_CYCLES cycles, then SELECT. `hopper_rdy` is ignored in PULSE and GAP.
- DONE: `done`=1 for exactly one cycle; `busy`<=0 on the exit edge; next IDLE.
- `change_req`/`inv_load` outside IDLE: ignored, no queuing.
- `change_amt`=0 → IDLE, SELECT, DONE. `done` asserted 2 cycles after acceptance, no pulses, `short`=0.
- Counters never underflow; a denomination with count 0 is never selected. Counters do not wrap.
- Arithmetic: `remaining` is unsigned AMT_W. The subtraction is only performed when `remaining` >= coin value, so it never goes negative.
- Per-coin cycle cost (with `hopper_rdy` high): 1 + PULSE_CYCLES + GAP_CYCLES.

Test Plan:
1. Reset, `change_amt`=8 (40c), `hopper_rdy`=1, defaults → pulse sequence Q, D, N, each 2 cycles high with 1 low gap. Final `remaining`=0; `q_cnt`/`d_cnt`/`n_cnt`=19/19/19; `done` 14 cycles after acceptance; `short`=0.
2. `inv_load` with q=0, d=1, n=1; then `change_amt`=5 → D then N ejected, then DONE. `remaining`=2, `short`=1, all counters 0.
3. `change_amt`=3, `hopper_rdy` held 0 for 10 cycles after acceptance → stays in SELECT with no pulses, `busy`=1. After `hopper_rdy` rises: D, N pulses; `done`; `short`=0.
4. `change_amt`=0 → no eject pulses, `done` one cycle 2 cycles after acceptance, `short`=0.
5. During a Q pulse, drive `reset`=0 for one cycle → `Q_out`, `busy`, `done` low next edge. Counters back to 20/20/20. A new `change_req`=1 is accepted normally afterwards.
6. While `busy`, pulse `change_req` with `change_amt`=10 and `inv_load` → both ignored. The original transaction completes unchanged; counters are not reloaded.
